cell_state_update: RTL
======================

# cell_state_update

Sequential LSTM cell-state update stage for forward propagation. For every cell index it fetches the previous state c(t-1) from `memory_cell` read port b and accepts the forget, input and candidate gate values (f, i, g) from the gate stage through a valid/ready handshake. It computes c(t) = f·c(t-1) + i·g in signed fixed point and writes the result back through `memory_cell` port a, also forwarding it downstream.

## Interface
Parameters:
- `ADDR`, 12, address width; matches `memory_cell`
- `WIDTH`, 32, signed data width
- `FRAC`, 24, fractional bits (1.0 = 0x01000000)
- `NUM`, 53*53, cells processed per run

Ports:
- `clk`  in  1  clock; all logic on the rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begins a run when sampled high in IDLE
- `in_valid`  in  1  f/i/g triple valid
- `in_ready`  out  1  stage accepts the triple
- `f_in`, `i_in`, `g_in`  in  WIDTH each  signed gate values
- `mem_addr_b`  out  ADDR  read address to `memory_cell`
- `mem_o_b`  in  WIDTH  registered read data (1-cycle latency)
- `mem_wr_a`  out  1  write strobe
- `mem_addr_a`  out  ADDR  write address
- `mem_i_a`  out  WIDTH  write data
- `c_out`  out  WIDTH  new cell state, valid with `c_valid`
- `c_valid`  out  1  one-cycle strobe per written cell
- `busy`  out  1  run in progress
- `done`  out  1  one-cycle pulse at end of run

## Operation
- FSM states and transitions:
  - IDLE: `start` → FETCH with idx=0.
  - FETCH: `mem_addr_b`=idx → ACCEPT.
  - ACCEPT: `in_ready`=1; on `in_valid`, register the result → WRITE.
  - WRITE: `mem_wr_a`=1, `mem_addr_a`=idx, `mem_i_a`=`c_out`=result, `c_valid`=1. If idx=NUM-1 → DONE; otherwise idx+1 → FETCH.
  - DONE: `done`=1 → IDLE.
- `mem_addr_b` holds idx continuously, so `mem_o_b` is stable for the whole of ACCEPT.
- Arithmetic:
  - Both products are full 2·WIDTH signed; their sum is 2·WIDTH+1 bits.
  - The sum is arithmetically shifted right by FRAC (truncation toward −∞), then reduced to WIDTH bits per Configuration.
- `start` is ignored outside IDLE.
- `in_ready` is low in every state except ACCEPT.
- `busy`=1 in FETCH, ACCEPT and WRITE.
- Reset asserted at any time:
  - State returns to IDLE and idx to 0; all outputs drop to 0 immediately (asynchronous).
  - No write is issued. Cells already written keep their new values.
- Reset value of every output is 0.

## Timing
- `start` sampled high at edge E0 → FETCH during E0..E1.
- With `in_valid` held high, each cell takes 3 cycles (FETCH, ACCEPT, WRITE).
- A run takes 3·NUM cycles plus 1 DONE cycle; `done` is high during cycle 3·NUM+1 after E0.
- A stall in ACCEPT extends that cell's time 1:1 with `in_valid` low cycles. `mem_addr_b` is held throughout.
- The WRITE of idx and the FETCH of idx+1 never overlap, so there is no read/write address collision.

## Configuration
- `CELL_SAT_EN` defined:
  - A shifted sum above 2^(WIDTH-1)-1 clamps to 0x7FFFFFFF.
  - A shifted sum below −2^(WIDTH-1) clamps to 0x80000000.
- `CELL_SAT_EN` undefined: the low WIDTH bits of the shifted sum are kept (wrap-around).

## Test plan
Bench uses NUM=4 and a `memory_cell` model.
- Reset: hold `rst`=0 → all outputs 0, `in_ready`=0; release, no `start` → stays idle, no writes.
- Basic update: c(t-1)=0x01000000, f=0x00800000, i=0x01000000, g=0x00400000 → `mem_wr_a` at addr 0 with data 0x00C00000; `c_valid` pulses once.
- Stall: `in_valid` low for 5 cycles in ACCEPT → `in_ready` stays 1, `mem_addr_b` constant, no write; the write occurs 1 cycle after `in_valid` rises.
- Saturation: f=c=0x7FFFFFFF, i=g=0 → 0x7FFFFFFF with `CELL_SAT_EN`, 0xFFFFFF00 without. f=0x80000000, c=0x7FFFFFFF with `CELL_SAT_EN` → 0x80000000.
- Full run: `in_valid` always high → writes to addresses 0,1,2,3 at cycles 3,6,9,12; `done` at cycle 13; a `start` pulse at cycle 5 is ignored.
- Mid-run reset: `rst`=0 during ACCEPT of idx 2 → `mem_wr_a`=0 immediately, outputs 0; only addresses 0 and 1 are updated; a new `start` restarts at idx 0.

Source files
------------

// File: rtl/cell_state_update_if.sv
// rtl/cell_state_update_if.sv - gate handshake, memory_cell ports and result strobe of cell_state_update
interface cell_state_update_if #(
  parameter int ADDR  = 12,
  parameter int WIDTH = 32
);
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] f_in;
  logic [WIDTH-1:0] i_in;
  logic [WIDTH-1:0] g_in;
  logic [ADDR-1:0]  mem_addr_b;
  logic [WIDTH-1:0] mem_o_b;
  logic             mem_wr_a;
  logic [ADDR-1:0]  mem_addr_a;
  logic [WIDTH-1:0] mem_i_a;
  logic [WIDTH-1:0] c_out;
  logic             c_valid;
  logic             busy;
  logic             done;

  // Environment side: gate stage, memory_cell and downstream consumer.
  modport master (
    output start, in_valid, f_in, i_in, g_in, mem_o_b,
    input  in_ready, mem_addr_b, mem_wr_a, mem_addr_a, mem_i_a, c_out, c_valid, busy, done
  );

  // Cell-state update stage side.
  modport slave (
    input  start, in_valid, f_in, i_in, g_in, mem_o_b,
    output in_ready, mem_addr_b, mem_wr_a, mem_addr_a, mem_i_a, c_out, c_valid, busy, done
  );
endinterface

// File: rtl/cell_state_update.sv
// rtl/cell_state_update.sv - LSTM c(t) = f*c(t-1) + i*g per cell; define CELL_SAT_EN to saturate instead of wrap
module cell_state_update #(
  parameter int ADDR  = 12,
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int NUM   = 53 * 53
) (
  input  logic               clk,
  input  logic               rst,
  cell_state_update_if.slave bus
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] ACCEPT = 3'd2;
  localparam logic [2:0] WRITE  = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [ADDR-1:0] LAST_IDX = ADDR'(NUM - 1);

  logic [2:0]       state;
  logic [ADDR-1:0]  idx;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_next;

  logic signed [2*WIDTH-1:0] f_ext;
  logic signed [2*WIDTH-1:0] c_ext;
  logic signed [2*WIDTH-1:0] i_ext;
  logic signed [2*WIDTH-1:0] g_ext;
  logic signed [2*WIDTH-1:0] prod_fc;
  logic signed [2*WIDTH-1:0] prod_ig;
  logic signed [2*WIDTH:0]   sum;
  logic signed [2*WIDTH:0]   shifted;

  // Operands are sign-extended so each product is exact at 2*WIDTH bits.
  assign f_ext   = {{WIDTH{bus.f_in[WIDTH-1]}}, bus.f_in};
  assign c_ext   = {{WIDTH{bus.mem_o_b[WIDTH-1]}}, bus.mem_o_b};
  assign i_ext   = {{WIDTH{bus.i_in[WIDTH-1]}}, bus.i_in};
  assign g_ext   = {{WIDTH{bus.g_in[WIDTH-1]}}, bus.g_in};
  assign prod_fc = f_ext * c_ext;
  assign prod_ig = i_ext * g_ext;

  // One extra bit keeps the sum of two full products from overflowing.
  assign sum     = {prod_fc[2*WIDTH-1], prod_fc} + {prod_ig[2*WIDTH-1], prod_ig};
  assign shifted = sum >>> FRAC;

`ifdef CELL_SAT_EN
  // Clamp when the bits above the kept field are not a pure sign extension.
  always_comb begin
    result_next = shifted[WIDTH-1:0];
    if (!(&shifted[2*WIDTH:WIDTH-1]) && (|shifted[2*WIDTH:WIDTH-1])) begin
      result_next = shifted[2*WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  // Keep the low WIDTH bits of the shifted sum; overflow wraps around.
  assign result_next = WIDTH'(shifted);
`endif

  // Per-cell sequencing: fetch c(t-1), wait for the gate triple, write c(t) back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      idx    <= '0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            idx   <= '0;
            state <= FETCH;
          end
        end
        FETCH: state <= ACCEPT;
        ACCEPT: begin
          if (bus.in_valid) begin
            result <= result_next;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (idx == LAST_IDX) begin
            state <= DONE;
          end else begin
            idx   <= idx + ADDR'(1);
            state <= FETCH;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the registers, so reset clears them at once.
  // The read address follows idx continuously, keeping mem_o_b stable through ACCEPT.
  assign bus.in_ready   = (state == ACCEPT);
  assign bus.mem_addr_b = idx;
  assign bus.mem_wr_a   = (state == WRITE);
  assign bus.mem_addr_a = idx;
  assign bus.mem_i_a    = result;
  assign bus.c_out      = result;
  assign bus.c_valid    = (state == WRITE);
  assign bus.busy       = (state == FETCH) || (state == ACCEPT) || (state == WRITE);
  assign bus.done       = (state == DONE);

endmodule
